// File: rtl/acq_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// acq_sequencer_pkg
// Shared definitions for the acquisition sequencer and anything that decodes
// its status readback (e.g. the MCU status register decoder).
//   STATE_W      : width of the encoded state readback
//   acq_state_t  : state encoding, fixed values so software can decode them
// -----------------------------------------------------------------------------
package acq_sequencer_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_PRE_FILL = 3'd1,
        ST_ARMED    = 3'd2,
        ST_POST     = 3'd3,
        ST_DONE     = 3'd4
    } acq_state_t;

endpackage

// File: rtl/acq_sequencer_sat_counter.sv
// -----------------------------------------------------------------------------
// acq_sequencer_sat_counter  (the sequencer's sat_counter)
// Saturating up-counter with synchronous clear and a terminal-count compare.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : synchronous clear to 0 (wins over i_en)
//   i_en           : advance by one; holds at all-ones instead of wrapping
//   i_tc_val       : terminal-count value, compared unsigned, full width
//   o_tc           : count currently equals i_tc_val
// -----------------------------------------------------------------------------
module acq_sequencer_sat_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_tc_val,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == i_tc_val);

endmodule

// File: rtl/acq_sequencer.sv
// -----------------------------------------------------------------------------
// acq_sequencer
// Logic-analyser acquisition sequencer: pre-trigger fill, arm, post-trigger
// window, then hold the buffer until the MCU has read it.
//
// Optional feature macro: ACQ_AUTO_TIMEOUT_EN
//   defined   -> auto-trigger timeout counter and FORCE_TRIG pulse are built
//   undefined -> o_force_trig tied 0, i_auto_to ignored, ARMED waits forever
//
// Ports
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_clk_en         : sample strobe; both counters advance only on it
//   i_start, i_stop  : one-cycle arm / abort requests (stop wins)
//   i_single         : 1 = single shot, 0 = re-arm after readout
//   i_read_ack       : MCU finished reading the buffer
//   i_pre_len        : pre-trigger samples, latched on entry to PRE_FILL
//   i_auto_to        : auto-trigger timeout in strobes, latched on entry to
//                      ARMED; 0 = wait for a real trigger only
//   i_sync_state     : trigger occurred
//   i_write_ready    : post-trigger window complete
//   o_start_write    : sample writing enabled (PRE_FILL, ARMED, POST)
//   o_enable_trig    : trigger detection enabled (ARMED)
//   o_force_trig     : one-cycle forced trigger on timeout
//   o_acq_done       : buffer complete, awaiting readout (DONE)
//   o_busy           : not IDLE
//   o_state          : encoded state for status readback
//
// state    | meaning
// IDLE     | waiting for START
// PRE_FILL | filling pre-trigger samples
// ARMED    | trigger detection enabled, optional timeout running
// POST     | trigger seen, filling post-trigger window
// DONE     | buffer complete, waiting for READ_ACK
// -----------------------------------------------------------------------------
module acq_sequencer
    import acq_sequencer_pkg::*;
#(
    parameter int PRE_W = 18,
    parameter int TO_W  = 24
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clk_en,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_single,
    input  logic               i_read_ack,
    input  logic [PRE_W-1:0]   i_pre_len,
    input  logic [TO_W-1:0]    i_auto_to,
    input  logic               i_sync_state,
    input  logic               i_write_ready,
    output logic               o_start_write,
    output logic               o_enable_trig,
    output logic               o_force_trig,
    output logic               o_acq_done,
    output logic               o_busy,
    output logic [STATE_W-1:0] o_state
);

    acq_state_t       r_state;
    logic [PRE_W-1:0] r_pre_len;
    logic             r_start_write;
    logic             r_enable_trig;
    logic             r_acq_done;
    logic             r_busy;

    logic             w_pre_clr;
    logic             w_pre_en;
    logic             w_pre_tc;
    logic [PRE_W-1:0] w_pre_last;

    // Counters are held clear outside their own state, so every entry
    // (START, re-arm, after STOP) starts counting from zero.
    assign w_pre_clr  = (r_state != ST_PRE_FILL);
    assign w_pre_en   = (r_state == ST_PRE_FILL) && i_clk_en;
    assign w_pre_last = r_pre_len - 1'b1;

    acq_sequencer_sat_counter #(.W(PRE_W)) u_pre_cnt (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (w_pre_clr),
        .i_en     (w_pre_en),
        .i_tc_val (w_pre_last),
        .o_tc     (w_pre_tc)
    );

`ifdef ACQ_AUTO_TIMEOUT_EN
    logic [TO_W-1:0] r_auto_to;
    logic            r_force_trig;
    logic            w_to_clr;
    logic            w_to_en;
    logic            w_to_tc;
    logic            w_to_hit;
    logic [TO_W-1:0] w_to_last;

    assign w_to_clr  = (r_state != ST_ARMED);
    assign w_to_en   = (r_state == ST_ARMED) && i_clk_en && (r_auto_to != '0);
    assign w_to_last = r_auto_to - 1'b1;
    // The counter passes the terminal value after the hit and saturates
    // above it, so the pulse cannot repeat within one ARMED visit.
    assign w_to_hit  = w_to_en && w_to_tc;

    acq_sequencer_sat_counter #(.W(TO_W)) u_to_cnt (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (w_to_clr),
        .i_en     (w_to_en),
        .i_tc_val (w_to_last),
        .o_tc     (w_to_tc)
    );

    assign o_force_trig = r_force_trig;
`else
    logic w_unused_auto_to;
    assign w_unused_auto_to = ^i_auto_to;
    assign o_force_trig     = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_pre_len     <= '0;
            r_start_write <= 1'b0;
            r_enable_trig <= 1'b0;
            r_acq_done    <= 1'b0;
            r_busy        <= 1'b0;
`ifdef ACQ_AUTO_TIMEOUT_EN
            r_auto_to     <= '0;
            r_force_trig  <= 1'b0;
`endif
        end else begin
`ifdef ACQ_AUTO_TIMEOUT_EN
            r_force_trig <= 1'b0;
`endif
            if (i_stop) begin
                r_state       <= ST_IDLE;
                r_start_write <= 1'b0;
                r_enable_trig <= 1'b0;
                r_acq_done    <= 1'b0;
                r_busy        <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_start) begin
                            r_state       <= ST_PRE_FILL;
                            r_pre_len     <= i_pre_len;
                            r_start_write <= 1'b1;
                            r_busy        <= 1'b1;
                        end
                    end
                    ST_PRE_FILL: begin
                        // A zero-length pre-fill arms immediately, no strobe needed.
                        if ((r_pre_len == '0) || (i_clk_en && w_pre_tc)) begin
                            r_state       <= ST_ARMED;
                            r_enable_trig <= 1'b1;
`ifdef ACQ_AUTO_TIMEOUT_EN
                            r_auto_to     <= i_auto_to;
`endif
                        end
                    end
                    ST_ARMED: begin
                        // A real trigger in the timeout cycle suppresses the forced one.
                        if (i_sync_state) begin
                            r_state       <= ST_POST;
                            r_enable_trig <= 1'b0;
                        end
`ifdef ACQ_AUTO_TIMEOUT_EN
                        else if (w_to_hit) begin
                            r_force_trig <= 1'b1;
                        end
`endif
                    end
                    ST_POST: begin
                        if (i_write_ready) begin
                            r_state       <= ST_DONE;
                            r_start_write <= 1'b0;
                            r_acq_done    <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (i_read_ack) begin
                            r_acq_done <= 1'b0;
                            if (i_single) begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state       <= ST_PRE_FILL;
                                r_pre_len     <= i_pre_len;
                                r_start_write <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state       <= ST_IDLE;
                        r_start_write <= 1'b0;
                        r_enable_trig <= 1'b0;
                        r_acq_done    <= 1'b0;
                        r_busy        <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_start_write = r_start_write;
    assign o_enable_trig = r_enable_trig;
    assign o_acq_done    = r_acq_done;
    assign o_busy        = r_busy;
    assign o_state       = r_state;

endmodule

// File: tb/tb_acq_sequencer.sv
// -----------------------------------------------------------------------------
// tb_acq_sequencer
// Inputs are applied on the falling edge; a reference model computes what the
// outputs must be after the next rising edge and queues it. A separate monitor
// pops one entry 2 time units after each rising edge and compares every output.
// Directed sequences add explicit spot checks on the key transitions, then a
// randomized run exercises all paths. Honours ACQ_AUTO_TIMEOUT_EN like the RTL.
// -----------------------------------------------------------------------------
module tb_acq_sequencer;

    localparam int PRE_W = 18;
    localparam int TO_W  = 24;
`ifdef ACQ_AUTO_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clk_en = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             single = 1'b0;
    logic             read_ack = 1'b0;
    logic             sync_state = 1'b0;
    logic             write_ready = 1'b0;
    logic [PRE_W-1:0] pre_len = '0;
    logic [TO_W-1:0]  auto_to = '0;

    logic             start_write;
    logic             enable_trig;
    logic             force_trig;
    logic             acq_done;
    logic             busy;
    logic [2:0]       state;

    always #5 clk = ~clk;

    acq_sequencer #(.PRE_W(PRE_W), .TO_W(TO_W)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_clk_en      (clk_en),
        .i_start       (start),
        .i_stop        (stop),
        .i_single      (single),
        .i_read_ack    (read_ack),
        .i_pre_len     (pre_len),
        .i_auto_to     (auto_to),
        .i_sync_state  (sync_state),
        .i_write_ready (write_ready),
        .o_start_write (start_write),
        .o_enable_trig (enable_trig),
        .o_force_trig  (force_trig),
        .o_acq_done    (acq_done),
        .o_busy        (busy),
        .o_state       (state)
    );

    typedef struct packed {
        logic       sw;
        logic       et;
        logic       ft;
        logic       ad;
        logic       bz;
        logic [2:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   tb_done = 1'b0;

    // Reference model: which phase the acquisition is in, how many strobes
    // have been seen in it and the lengths captured when it was entered.
    int m_phase;       // 0 idle, 1 pre-fill, 2 armed, 3 post, 4 done
    int m_fill_len;
    int m_fill_seen;
    int m_to_len;
    int m_to_seen;
    bit m_pulse;

    function automatic void chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, want, $time);
        end
    endfunction

    task automatic model_step();
        bit hit;
        hit     = 1'b0;
        m_pulse = 1'b0;
        if (!rst_n || stop) begin
            m_phase     = 0;
            m_fill_seen = 0;
            m_to_seen   = 0;
            return;
        end
        case (m_phase)
            0: if (start) begin
                m_phase = 1; m_fill_len = int'(pre_len); m_fill_seen = 0;
            end
            1: begin
                if (m_fill_len == 0) begin
                    m_phase = 2; m_to_len = int'(auto_to); m_to_seen = 0;
                end else if (clk_en) begin
                    m_fill_seen++;
                    if (m_fill_seen == m_fill_len) begin
                        m_phase = 2; m_to_len = int'(auto_to); m_to_seen = 0;
                    end
                end
            end
            2: begin
                if (TO_EN && m_to_len != 0 && clk_en) begin
                    m_to_seen++;
                    hit = (m_to_seen == m_to_len);
                end
                if (sync_state) m_phase = 3;
                else if (hit)   m_pulse = 1'b1;
            end
            3: if (write_ready) m_phase = 4;
            4: if (read_ack) begin
                if (single) m_phase = 0;
                else begin
                    m_phase = 1; m_fill_len = int'(pre_len); m_fill_seen = 0;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    // Called on a falling edge with the inputs already set for the coming
    // rising edge; returns on the following falling edge.
    task automatic tick();
        exp_t e;
        model_step();
        e.sw = (m_phase >= 1 && m_phase <= 3);
        e.et = (m_phase == 2);
        e.ft = m_pulse;
        e.ad = (m_phase == 4);
        e.bz = (m_phase != 0);
        e.st = 3'(m_phase);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        clk_en = 0; start = 0; stop = 0; read_ack = 0; sync_state = 0; write_ready = 0;
    endtask

    initial begin : monitor
        exp_t e;
        while (!tb_done) begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("start_write", int'(start_write), int'(e.sw));
                chk("enable_trig", int'(enable_trig), int'(e.et));
                chk("force_trig",  int'(force_trig),  int'(e.ft));
                chk("acq_done",    int'(acq_done),    int'(e.ad));
                chk("busy",        int'(busy),        int'(e.bz));
                chk("state",       int'(state),       int'(e.st));
            end
        end
    end

    initial begin : stim
        m_phase = 0; m_fill_len = 0; m_fill_seen = 0; m_to_len = 0; m_to_seen = 0; m_pulse = 0;
        @(negedge clk);

        // reset
        repeat (3) tick();
        chk("reset_state", int'(state), 0);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick();

        // pre-fill of 4 with strobe every 2nd cycle, trigger, window, single readout
        pre_len = 4; single = 1; start = 1; tick(); start = 0;
        chk("prefill_entry", int'(state), 1);
        chk("prefill_sw", int'(start_write), 1);
        for (int i = 0; i < 8; i++) begin
            clk_en = (i % 2 == 0);
            tick();
            if (i == 5) chk("et_before_4th", int'(enable_trig), 0);
        end
        clk_en = 0;
        chk("armed_after_4", int'(state), 2);
        chk("et_armed", int'(enable_trig), 1);
        sync_state = 1; tick(); sync_state = 0;
        chk("post_state", int'(state), 3);
        chk("post_et", int'(enable_trig), 0);
        repeat (2) tick();
        write_ready = 1; tick(); write_ready = 0;
        chk("done_ad", int'(acq_done), 1);
        chk("done_sw", int'(start_write), 0);
        read_ack = 1; tick(); read_ack = 0;
        chk("single_idle", int'(state), 0);
        chk("single_busy", int'(busy), 0);

        // repeat mode re-arms with a fresh counter; stop; start+stop together
        single = 0; pre_len = 2; start = 1; tick(); start = 0;
        clk_en = 1; repeat (2) tick(); clk_en = 0;
        sync_state = 1; tick(); sync_state = 0;
        write_ready = 1; tick(); write_ready = 0;
        read_ack = 1; tick(); read_ack = 0;
        chk("rearm_prefill", int'(state), 1);
        chk("rearm_ad", int'(acq_done), 0);
        clk_en = 1; tick();
        chk("rearm_1strobe", int'(state), 1);
        tick(); clk_en = 0;
        chk("rearm_2strobe", int'(state), 2);
        stop = 1; tick(); stop = 0;
        chk("stop_idle", int'(state), 0);
        chk("stop_sw", int'(start_write), 0);
        start = 1; stop = 1; tick(); start = 0; stop = 0;
        chk("start_stop_idle", int'(state), 0);

        // pre_len latched at entry
        pre_len = 3; start = 1; tick(); start = 0;
        pre_len = 1; clk_en = 1; tick();
        chk("latched_len", int'(state), 1);
        repeat (2) tick(); clk_en = 0;
        chk("latched_armed", int'(state), 2);
        start = 1; tick(); start = 0;
        chk("start_ignored", int'(state), 2);
        stop = 1; tick(); stop = 0;

        // asynchronous reset during POST, then no progress without START
        pre_len = 0; start = 1; tick(); start = 0;
        tick();
        chk("zero_len_armed", int'(state), 2);
        sync_state = 1; tick(); sync_state = 0;
        chk("pre_reset_post", int'(state), 3);
        #2 rst_n = 0;
        #1;
        chk("async_state", int'(state), 0);
        chk("async_sw", int'(start_write), 0);
        chk("async_busy", int'(busy), 0);
        repeat (2) tick();
        rst_n = 1; sync_state = 1; write_ready = 1; read_ack = 1; clk_en = 1;
        repeat (4) tick();
        clear_inputs();
        chk("no_done_after_rst", int'(acq_done), 0);
        chk("idle_after_rst", int'(state), 0);

        // timeout of 10 strobes, then the same with a coincident real trigger
        for (int k = 0; k < 2; k++) begin
            pre_len = 0; auto_to = 10; start = 1; tick(); start = 0;
            tick();
            auto_to = 3;
            clk_en = 1;
            repeat (9) tick();
            chk("ft_before_10", int'(force_trig), 0);
            if (k == 1) sync_state = 1;
            tick();
            clk_en = 0; sync_state = 0;
            chk("ft_at_10", int'(force_trig), (TO_EN && k == 0) ? 1 : 0);
            chk("state_at_10", int'(state), (k == 1) ? 3 : 2);
            if (k == 0) begin
                tick();
                chk("ft_one_cycle", int'(force_trig), 0);
                sync_state = 1; tick(); sync_state = 0;
                chk("loopback_post", int'(state), 3);
            end
            stop = 1; tick(); stop = 0;
        end
        auto_to = 0;

        // randomized run
        for (int n = 0; n < 4000; n++) begin
            rst_n       = ($urandom_range(999) >= 3);
            clk_en      = $urandom_range(1);
            start       = ($urandom_range(99) < 15);
            stop        = ($urandom_range(99) < 2);
            single      = $urandom_range(1);
            read_ack    = ($urandom_range(99) < 15);
            sync_state  = ($urandom_range(99) < 6);
            write_ready = ($urandom_range(99) < 15);
            if ($urandom_range(9) == 0) pre_len = PRE_W'($urandom_range(6));
            if ($urandom_range(9) == 0) auto_to = TO_W'($urandom_range(12));
            tick();
        end
        rst_n = 1; clear_inputs();
        repeat (2) tick();

        tb_done = 1'b1;
        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/acq_sequencer.md
ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 SHALL have parameter PRE_W, default 18, width of the pre-trigger sample counter and PRE_LEN.
REQ-002 SHALL have parameter TO_W, default 24, width of the auto-trigger timeout counter and AUTO_TO.
REQ-003 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port CLK_EN  input  1  sample strobe; all counters advance only when high.
REQ-006 SHALL have port START  input  1  one-cycle arm request from MCU interface.
REQ-007 SHALL have port STOP  input  1  one-cycle abort.
REQ-008 SHALL have port SINGLE  input  1  1 = single shot, 0 = repeat.
REQ-009 SHALL have port READ_ACK  input  1  MCU finished reading the buffer.
REQ-010 SHALL have port PRE_LEN  input  PRE_W  pre-trigger samples to fill before arming.
REQ-011 SHALL have port AUTO_TO  input  TO_W  auto-trigger timeout in CLK_EN samples; 0 = normal mode.
REQ-012 SHALL have port SYNC_STATE  input  1  trigger-occurred flag from the synchronization block.
REQ-013 SHALL have port WRITE_READY  input  1  post-trigger window complete from the synchronization block.
REQ-014 SHALL have port START_WRITE  output  1  enables sample writing and window counting.
REQ-015 SHALL have port ENABLE_TRIG  output  1  enables trigger detection.
REQ-016 SHALL have port FORCE_TRIG  output  1  one-cycle forced trigger pulse, ORed upstream into the LA trigger input.
REQ-017 SHALL have port ACQ_DONE  output  1  buffer complete, awaiting readout.
REQ-018 SHALL have port BUSY  output  1  state is not IDLE.
REQ-019 SHALL have port STATE  output  3  encoded state for status readback.

Function
REQ-020 SHALL implement states IDLE=0, PRE_FILL=1, ARMED=2, POST=3, DONE=4; all outputs SHALL be registered.
REQ-021 IDLE: START → PRE_FILL next cycle, pre-trigger counter cleared, START_WRITE=1.
REQ-022 PRE_FILL: counter increments on CLK_EN; at count==PRE_LEN-1 with CLK_EN → ARMED; PRE_LEN=0 → ARMED on the next cycle regardless of CLK_EN.
REQ-023 ARMED: ENABLE_TRIG=1; SYNC_STATE=1 → POST next cycle, ENABLE_TRIG=0.
REQ-024 ARMED with AUTO_TO≠0: timeout counter increments on CLK_EN; at count==AUTO_TO-1 with CLK_EN and SYNC_STATE=0 → FORCE_TRIG=1 for exactly one cycle, state remains ARMED until SYNC_STATE.
REQ-025 SYNC_STATE=1 and timeout reached in the same cycle → no FORCE_TRIG; real trigger wins.
REQ-026 POST: START_WRITE held 1; WRITE_READY=1 → DONE next cycle, START_WRITE=0, ACQ_DONE=1.
REQ-027 DONE: READ_ACK with SINGLE=1 → IDLE; READ_ACK with SINGLE=0 → PRE_FILL (re-arm, counters cleared); ACQ_DONE cleared on exit.
REQ-028 STOP in any state → IDLE next cycle, all outputs 0, counters cleared; STOP and START in the same cycle → STOP wins.
REQ-029 START outside IDLE SHALL be ignored.
REQ-030 Counters SHALL saturate and never wrap; comparisons are unsigned, full width.
REQ-031 Input changes to PRE_LEN/AUTO_TO SHALL take effect only on entry to PRE_FILL/ARMED (latched at entry).

Reset
REQ-032 RST_N low SHALL asynchronously force IDLE, all outputs 0, STATE=0, all counters 0.
REQ-033 Reset mid-acquisition SHALL discard progress; no ACQ_DONE is produced after release until a new START.

Configuration
REQ-034 With ACQ_AUTO_TIMEOUT_EN defined, REQ-024/025 and FORCE_TRIG logic SHALL be built.
REQ-035 Without ACQ_AUTO_TIMEOUT_EN, FORCE_TRIG SHALL be tied 0, AUTO_TO ignored, timeout counter absent; ARMED waits indefinitely.

Structure
REQ-036 State encodings and STATE width SHALL live in shared include acq_defs.v, reused by the MCU status register decoder.
REQ-037 A sub-module sat_counter (parameterized width, clear, enable, terminal-count compare) SHALL be used for both counters.

Verification
REQ-038 PRE_LEN=4, CLK_EN every 2nd cycle, START → ARMED after 4 strobes (8 cycles); ENABLE_TRIG rises then.
REQ-039 ARMED, SYNC_STATE pulse → POST; WRITE_READY → DONE, ACQ_DONE=1, START_WRITE=0; READ_ACK with SINGLE=1 → IDLE, BUSY=0.
REQ-040 AUTO_TO=10, no trigger → FORCE_TRIG single pulse after 10th strobe in ARMED; loopback SYNC_STATE → POST.
REQ-041 SYNC_STATE coincident with 10th timeout strobe → FORCE_TRIG stays 0, POST entered.
REQ-042 SINGLE=0, READ_ACK in DONE → PRE_FILL with counter 0; START+STOP same cycle in IDLE → stays IDLE.
REQ-043 RST_N low during POST → outputs 0 immediately (asynchronous); after release, START required to restart.
